// File: rtl/frame_scanout_if.sv
// Frame-buffer read port and VGA pin bundle for frame_scanout.
// SCANOUT_TESTPATTERN_EN adds the test_mode select.
interface frame_scanout_if #(
  parameter int DATA_WIDTH = 12,
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 10
);
  logic [X_WIDTH+Y_WIDTH-1:0] rd_address;
  logic [DATA_WIDTH-1:0]      rd_data;
  logic [3:0]                 vga_r;
  logic [3:0]                 vga_g;
  logic [3:0]                 vga_b;
  logic                       hsync;
  logic                       vsync;
  logic                       active;
  logic                       frame_start;
`ifdef SCANOUT_TESTPATTERN_EN
  logic                       test_mode;

  modport master (
    output rd_address, vga_r, vga_g, vga_b, hsync, vsync, active, frame_start,
    input  rd_data, test_mode
  );
  modport slave (
    input  rd_address, vga_r, vga_g, vga_b, hsync, vsync, active, frame_start,
    output rd_data, test_mode
  );
`else
  modport master (
    output rd_address, vga_r, vga_g, vga_b, hsync, vsync, active, frame_start,
    input  rd_data
  );
  modport slave (
    input  rd_address, vga_r, vga_g, vga_b, hsync, vsync, active, frame_start,
    output rd_data
  );
`endif
endinterface

// File: rtl/frame_scanout.sv
// VGA scanout from the pixel frame buffer: timing counters, buffer read, aligned RGB/sync outputs.
// Optional SCANOUT_TESTPATTERN_EN adds a test_mode colour-bar source.
module frame_scanout #(
  parameter int DATA_WIDTH = 12,
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 10,
  parameter int CLK_DIV    = 4,
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic              clock,
  input  logic              reset_n,
  frame_scanout_if.master   scan
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [X_WIDTH-1:0] H_LAST   = X_WIDTH'(H_TOTAL - 1);
  localparam logic [X_WIDTH-1:0] H_VIS    = X_WIDTH'(H_VISIBLE);
  localparam logic [X_WIDTH-1:0] HS_FIRST = X_WIDTH'(H_VISIBLE + H_FP);
  localparam logic [X_WIDTH-1:0] HS_LAST  = X_WIDTH'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [Y_WIDTH-1:0] V_LAST   = Y_WIDTH'(V_TOTAL - 1);
  localparam logic [Y_WIDTH-1:0] V_VIS    = Y_WIDTH'(V_VISIBLE);
  localparam logic [Y_WIDTH-1:0] VS_FIRST = Y_WIDTH'(V_VISIBLE + V_FP);
  localparam logic [Y_WIDTH-1:0] VS_LAST  = Y_WIDTH'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0]      r_div_cnt;
  logic [X_WIDTH-1:0]    r_h_cnt;
  logic [Y_WIDTH-1:0]    r_v_cnt;
  logic                  r_tick_d1;
  logic                  r_tick_d2;
  logic                  r_vis_d;
  logic [DATA_WIDTH-1:0] r_rgb;
  logic                  r_hsync;
  logic                  r_vsync;
  logic                  r_active;
  logic                  r_frame_start;

  logic                  w_pixel_tick;
  logic                  w_h_wrap;
  logic                  w_v_wrap;
  logic                  w_vis;
  logic                  w_hsync_n;
  logic                  w_vsync_n;
  logic [DATA_WIDTH-1:0] w_pix_src;

`ifdef SCANOUT_TESTPATTERN_EN
  function automatic logic [DATA_WIDTH-1:0] bar_colour(input logic [X_WIDTH-1:0] h);
    logic [X_WIDTH-1:0] idx;
    idx = h / X_WIDTH'(80);
    case (idx)
      X_WIDTH'(0): bar_colour = DATA_WIDTH'(12'hFFF);
      X_WIDTH'(1): bar_colour = DATA_WIDTH'(12'hFF0);
      X_WIDTH'(2): bar_colour = DATA_WIDTH'(12'h0FF);
      X_WIDTH'(3): bar_colour = DATA_WIDTH'(12'h0F0);
      X_WIDTH'(4): bar_colour = DATA_WIDTH'(12'hF0F);
      X_WIDTH'(5): bar_colour = DATA_WIDTH'(12'hF00);
      X_WIDTH'(6): bar_colour = DATA_WIDTH'(12'h00F);
      default:     bar_colour = DATA_WIDTH'(12'h000);
    endcase
  endfunction
`endif

  // Pixel strobe, wrap detection, visible window and sync decodes from the live counters.
  always_comb begin
    w_pixel_tick = (r_div_cnt == DIV_LAST);
    w_h_wrap     = w_pixel_tick && (r_h_cnt == H_LAST);
    w_v_wrap     = (r_v_cnt == V_LAST);
    w_vis        = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    w_hsync_n    = !((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST));
    w_vsync_n    = !((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST));
`ifdef SCANOUT_TESTPATTERN_EN
    if (scan.test_mode) begin
      w_pix_src = bar_colour(r_h_cnt);
    end else begin
      w_pix_src = scan.rd_data;
    end
`else
    w_pix_src    = scan.rd_data;
`endif
  end

  assign scan.rd_address = w_vis ? {r_v_cnt, r_h_cnt} : (X_WIDTH + Y_WIDTH)'(0);

  // Clock divider, raster counters and the frame-start strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt     <= DIV_W'(0);
      r_h_cnt       <= X_WIDTH'(0);
      r_v_cnt       <= Y_WIDTH'(0);
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_h_wrap && w_v_wrap;
      if (w_pixel_tick) begin
        r_div_cnt <= DIV_W'(0);
        if (w_h_wrap) begin
          r_h_cnt <= X_WIDTH'(0);
          r_v_cnt <= w_v_wrap ? Y_WIDTH'(0) : r_v_cnt + Y_WIDTH'(1);
        end else begin
          r_h_cnt <= r_h_cnt + X_WIDTH'(1);
        end
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  // Output stage loads two clocks after a counter step, once the buffer word for that
  // address has arrived; counters are still on the same pixel, so colour and syncs align.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_d1 <= 1'b0;
      r_tick_d2 <= 1'b0;
      r_vis_d   <= 1'b0;
      r_rgb     <= DATA_WIDTH'(0);
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_active  <= 1'b0;
    end else begin
      r_tick_d1 <= w_pixel_tick;
      r_tick_d2 <= r_tick_d1;
      r_vis_d   <= w_vis;
      if (r_tick_d2) begin
        r_rgb    <= r_vis_d ? w_pix_src : DATA_WIDTH'(0);
        r_hsync  <= w_hsync_n;
        r_vsync  <= w_vsync_n;
        r_active <= w_vis;
      end
    end
  end

  assign scan.vga_r       = r_rgb[11:8];
  assign scan.vga_g       = r_rgb[7:4];
  assign scan.vga_b       = r_rgb[3:0];
  assign scan.hsync       = r_hsync;
  assign scan.vsync       = r_vsync;
  assign scan.active      = r_active;
  assign scan.frame_start = r_frame_start;

endmodule

// File: tb/tb_frame_scanout.sv
// Self-checking bench for frame_scanout: a full-size 640x480 instance and a shrunken-raster
// instance (CLK_DIV=2) compared every clock against a cycle-count arithmetic model.
module tb_frame_scanout;

  localparam int FA_DIV = 4;
  localparam int FA_HV = 640, FA_HFP = 16, FA_HS = 96, FA_HBP = 48;
  localparam int FA_VV = 480, FA_VFP = 10, FA_VS = 2, FA_VBP = 33;
  localparam int FA_HT = FA_HV + FA_HFP + FA_HS + FA_HBP;
  localparam int FA_VT = FA_VV + FA_VFP + FA_VS + FA_VBP;

  localparam int SB_DIV = 2;
  localparam int SB_HV = 16, SB_HFP = 2, SB_HS = 3, SB_HBP = 3;
  localparam int SB_VV = 6, SB_VFP = 1, SB_VS = 2, SB_VBP = 1;
  localparam int SB_HT = SB_HV + SB_HFP + SB_HS + SB_HBP;
  localparam int SB_VT = SB_VV + SB_VFP + SB_VS + SB_VBP;

  // {frame_start, active, vsync, hsync, rgb[11:0], rd_address[19:0]}
  localparam logic [35:0] RESET_VEC = {1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 20'h00000};

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;

  frame_scanout_if #(.DATA_WIDTH(12), .X_WIDTH(10), .Y_WIDTH(10)) ifa ();
  frame_scanout_if #(.DATA_WIDTH(12), .X_WIDTH(10), .Y_WIDTH(10)) ifb ();

  frame_scanout #(
    .DATA_WIDTH(12), .X_WIDTH(10), .Y_WIDTH(10), .CLK_DIV(FA_DIV),
    .H_VISIBLE(FA_HV), .H_FP(FA_HFP), .H_SYNC(FA_HS), .H_BP(FA_HBP),
    .V_VISIBLE(FA_VV), .V_FP(FA_VFP), .V_SYNC(FA_VS), .V_BP(FA_VBP)
  ) dut_a (.clock(clk), .reset_n(rst_a_n), .scan(ifa));

  frame_scanout #(
    .DATA_WIDTH(12), .X_WIDTH(10), .Y_WIDTH(10), .CLK_DIV(SB_DIV),
    .H_VISIBLE(SB_HV), .H_FP(SB_HFP), .H_SYNC(SB_HS), .H_BP(SB_HBP),
    .V_VISIBLE(SB_VV), .V_FP(SB_VFP), .V_SYNC(SB_VS), .V_BP(SB_VBP)
  ) dut_b (.clock(clk), .reset_n(rst_b_n), .scan(ifb));

`ifdef SCANOUT_TESTPATTERN_EN
  assign ifa.test_mode = 1'b0;
  assign ifb.test_mode = 1'b0;
`endif

  always #5 clk = ~clk;

  int          mode_a, mode_b;
  logic [11:0] salt_a, salt_b;

  function automatic logic [11:0] memfn(input int mode, input logic [11:0] salt, input logic [19:0] addr);
    if (mode == 1) return 12'hFFF;
    return {addr[13:10], addr[7:0]} ^ salt;
  endfunction

  // Frame-buffer models: one-clock read latency.
  always @(posedge clk) ifa.rd_data <= memfn(mode_a, salt_a, ifa.rd_address);
  always @(posedge clk) ifb.rd_data <= memfn(mode_b, salt_b, ifb.rd_address);

  logic [35:0] obs_a, obs_b;
  assign obs_a = {ifa.frame_start, ifa.active, ifa.vsync, ifa.hsync,
                  ifa.vga_r, ifa.vga_g, ifa.vga_b, ifa.rd_address};
  assign obs_b = {ifb.frame_start, ifb.active, ifb.vsync, ifb.hsync,
                  ifb.vga_r, ifb.vga_g, ifb.vga_b, ifb.rd_address};

  int checks = 0;
  int passed = 0;

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected pins n clocks after reset release: the raster position is n/div pixels in,
  // and the output pins show the pixel entered two clocks earlier (first load is pixel 1).
  function automatic logic [35:0] model(input int n, input bit run, input int div,
                                        input int ht, input int hv, input int hfp, input int hs,
                                        input int vt, input int vv, input int vfp, input int vs,
                                        input int mode, input logic [11:0] salt);
    int c, s, h, v;
    logic [19:0] addr;
    logic [11:0] rgb;
    logic fs, act, hsn, vsn;
    if (!run) return RESET_VEC;
    c    = n / div;
    h    = c % ht;
    v    = (c / ht) % vt;
    addr = (h < hv && v < vv) ? {v[9:0], h[9:0]} : 20'h00000;
    fs   = (n > 0) && (n % div == 0) && (c % (ht * vt) == 0);
    if (n < div + 2) begin
      act = 1'b0; hsn = 1'b1; vsn = 1'b1; rgb = 12'h000;
    end else begin
      s   = (n - 2) / div;
      h   = s % ht;
      v   = (s / ht) % vt;
      act = (h < hv) && (v < vv);
      hsn = !(h >= hv + hfp && h < hv + hfp + hs);
      vsn = !(v >= vv + vfp && v < vv + vfp + vs);
      rgb = act ? memfn(mode, salt, {v[9:0], h[9:0]}) : 12'h000;
    end
    return {fs, act, vsn, hsn, rgb, addr};
  endfunction

  int na, nb;
  bit run_a, run_b;
  bit prev_hs_a, prev_vs_b, prev_fs_b;
  int a_falls[$], a_rises[$], b_vfalls[$], b_vrises[$], b_fs[$];
  int fs_run, fs_maxw, blank_bad, vis_seen;

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (run_a) na++;
    if (run_b) nb++;
    check_eq("vec_a", obs_a, model(na, run_a, FA_DIV, FA_HT, FA_HV, FA_HFP, FA_HS,
                                   FA_VT, FA_VV, FA_VFP, FA_VS, mode_a, salt_a));
    check_eq("vec_b", obs_b, model(nb, run_b, SB_DIV, SB_HT, SB_HV, SB_HFP, SB_HS,
                                   SB_VT, SB_VV, SB_VFP, SB_VS, mode_b, salt_b));
    if (run_a && na == FA_DIV * (3 * FA_HT + 5) + 2)
      check_eq("pix_5_3", {23'd0, ifa.active, ifa.vga_r, ifa.vga_g, ifa.vga_b},
               {23'd0, 1'b1, 12'h305 ^ salt_a});
    if (run_a && prev_hs_a && !ifa.hsync) a_falls.push_back(na);
    if (run_a && !prev_hs_a && ifa.hsync) a_rises.push_back(na);
    prev_hs_a = ifa.hsync;
    if (run_b && prev_vs_b && !ifb.vsync) b_vfalls.push_back(nb);
    if (run_b && !prev_vs_b && ifb.vsync) b_vrises.push_back(nb);
    prev_vs_b = ifb.vsync;
    if (run_b && ifb.frame_start) begin
      if (!prev_fs_b) b_fs.push_back(nb);
      fs_run++;
      if (fs_run > fs_maxw) fs_maxw = fs_run;
    end else begin
      fs_run = 0;
    end
    prev_fs_b = ifb.frame_start;
    if (run_b && mode_b == 1 && !ifb.active && {ifb.vga_r, ifb.vga_g, ifb.vga_b} != 12'h000)
      blank_bad++;
    if (run_b && mode_b == 1 && ifb.active) vis_seen++;
  endtask

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    run_a = 1'b0; run_b = 1'b0; na = 0; nb = 0;
    mode_a = 0; mode_b = 0;
    salt_a = 12'($urandom); salt_b = 12'($urandom);
    prev_hs_a = 1'b1; prev_vs_b = 1'b1; prev_fs_b = 1'b0;
    fs_run = 0; fs_maxw = 0; blank_bad = 0; vis_seen = 0;

    repeat (4) step();
    check_eq("rst_hold_a", obs_a, RESET_VEC);
    check_eq("rst_hold_b", obs_b, RESET_VEC);

    @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1; run_a = 1'b1; run_b = 1'b1;
    repeat (9700) step();

    check_eq("hs_first_fall", 36'(qat(a_falls, 0)), 36'(FA_DIV * (FA_HV + FA_HFP) + 2));
    check_eq("hs_period", 36'(qat(a_falls, 1) - qat(a_falls, 0)), 36'(FA_DIV * FA_HT));
    check_eq("hs_low_width", 36'(qat(a_rises, 0) - qat(a_falls, 0)), 36'(FA_DIV * FA_HS));
    check_eq("vs_first_fall", 36'(qat(b_vfalls, 0)), 36'(SB_DIV * (SB_VV + SB_VFP) * SB_HT + 2));
    check_eq("vs_period", 36'(qat(b_vfalls, 1) - qat(b_vfalls, 0)), 36'(SB_DIV * SB_HT * SB_VT));
    check_eq("vs_low_width", 36'(qat(b_vrises, 0) - qat(b_vfalls, 0)), 36'(SB_DIV * SB_VS * SB_HT));
    check_eq("fs_first", 36'(qat(b_fs, 0)), 36'(SB_DIV * SB_HT * SB_VT));
    check_eq("fs_spacing", 36'(qat(b_fs, 1) - qat(b_fs, 0)), 36'(SB_DIV * SB_HT * SB_VT));
    check_eq("fs_width", 36'(fs_maxw), 36'd1);

    // Walk the full instance to column 320 of a visible line, then drop reset between edges.
    for (int i = 0; i < 4 * FA_HT * FA_DIV && (na / FA_DIV) % FA_HT != 320; i++) step();
    check_eq("pre_rst_col", 36'(ifa.rd_address[9:0]), 36'd320);
    #2;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    #1;
    check_eq("async_rst_a", obs_a, RESET_VEC);
    check_eq("async_rst_b", obs_b, RESET_VEC);
    run_a = 1'b0; run_b = 1'b0; na = 0; nb = 0;
    mode_b = 1; salt_a = 12'($urandom);
    b_vfalls.delete(); b_vrises.delete(); b_fs.delete();
    repeat (3) step();

    @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1; run_a = 1'b1; run_b = 1'b1;
    #1;
    check_eq("restart_addr0", 36'(ifa.rd_address), 36'd0);
    repeat (4) step();
    check_eq("restart_addr1", 36'(ifa.rd_address), 36'd1);
    repeat (4) step();
    check_eq("restart_addr2", 36'(ifa.rd_address), 36'd2);
    repeat (1100) step();

    check_eq("blank_rgb_zero", 36'(blank_bad), 36'd0);
    check_eq("fff_visible_seen", 36'(vis_seen > 0), 36'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
